// File: rtl/write_back_pkg.sv
// rtl/write_back_pkg.sv - shared processor types used by the write-back stage
package write_back_pkg;

  typedef logic [4:0]  regind_t;
  typedef logic [31:0] regval_t;
  typedef logic [3:0]  flags_t;

  // Register index that aliases the architectural flags register
  localparam regind_t FLAGS_INDEX = 5'd30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UPPER = 2'd1,
    STORE = 2'd2
  } write_back_state_t;

endpackage

// File: rtl/write_back.sv
// rtl/write_back.sv - write-back stage: register/flag writes, upper-half writes, memory stores
// Optional feature: WRITE_BACK_FEEDBACK_EN drives fb_* from the register-file write port.
module write_back
  import write_back_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    in_valid,
  output logic    in_hold,
  input  regval_t in_pc,
  input  regind_t in_destination_register,
  input  logic    in_is_writing_memory,
  input  flags_t  in_flags,
  input  regval_t in_destination_value,
  input  logic    in_has_upper_value,
  input  regval_t in_upper_value,
  input  regval_t in_adjustment_value,
  input  logic    in_has_flushed,
  output logic    rf_we,
  output regind_t rf_index,
  output regval_t rf_value,
  output flags_t  flags_we,
  output flags_t  flags_value,
  output regind_t rf_read_index,
  input  regval_t rf_read_value,
  output logic    mem_write,
  output regval_t mem_address,
  output regval_t mem_data,
  input  logic    mem_wait_request,
  output logic    retire_valid,
  output regval_t retire_pc,
  output logic    fb_valid,
  output regind_t fb_index,
  output regval_t fb_value
);

  write_back_state_t r_state;
  logic              r_rf_we;
  regind_t           r_rf_index;
  regval_t           r_rf_value;
  flags_t            r_flags_we;
  flags_t            r_flags_value;
  logic              r_mem_write;
  regval_t           r_mem_address;
  regval_t           r_mem_data;
  logic              r_retire_valid;
  regval_t           r_pc;
  regind_t           r_upper_index;
  regval_t           r_upper_value;
  logic              w_accept;

  assign in_hold       = reset || (r_state != IDLE);
  assign w_accept      = in_valid && !in_hold;
  // Store data is fetched from the register file in the same cycle the beat is accepted
  assign rf_read_index = in_destination_register;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= IDLE;
      r_rf_we        <= 1'b0;
      r_rf_index     <= '0;
      r_rf_value     <= '0;
      r_flags_we     <= '0;
      r_flags_value  <= '0;
      r_mem_write    <= 1'b0;
      r_mem_address  <= '0;
      r_mem_data     <= '0;
      r_retire_valid <= 1'b0;
      r_pc           <= '0;
      r_upper_index  <= '0;
      r_upper_value  <= '0;
    end else begin
      r_rf_we        <= 1'b0;
      r_flags_we     <= '0;
      r_retire_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept && !in_has_flushed) begin
            r_pc <= in_pc;
            if (in_is_writing_memory) begin
              r_mem_write   <= 1'b1;
              r_mem_address <= in_destination_value + in_adjustment_value;
              r_mem_data    <= rf_read_value;
              r_state       <= STORE;
            end else begin
              r_rf_we       <= (in_destination_register != '0);
              r_rf_index    <= in_destination_register;
              r_rf_value    <= in_destination_value;
              // A direct write to the flags register wins over the implicit flag update
              r_flags_we    <= (in_destination_register == FLAGS_INDEX) ? 4'b0000 : 4'b1111;
              r_flags_value <= in_flags;
              if (in_has_upper_value) begin
                r_upper_index <= regind_t'(in_destination_register + 5'd1);
                r_upper_value <= in_upper_value;
                r_state       <= UPPER;
              end else begin
                r_retire_valid <= 1'b1;
              end
            end
          end
        end
        UPPER: begin
          r_rf_we        <= (r_upper_index != '0);
          r_rf_index     <= r_upper_index;
          r_rf_value     <= r_upper_value;
          r_retire_valid <= 1'b1;
          r_state        <= IDLE;
        end
        STORE: begin
          if (!mem_wait_request) begin
            r_mem_write    <= 1'b0;
            r_retire_valid <= 1'b1;
            r_state        <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rf_we        = r_rf_we;
  assign rf_index     = r_rf_index;
  assign rf_value     = r_rf_value;
  assign flags_we     = r_flags_we;
  assign flags_value  = r_flags_value;
  assign mem_write    = r_mem_write;
  assign mem_address  = r_mem_address;
  assign mem_data     = r_mem_data;
  assign retire_valid = r_retire_valid;
  assign retire_pc    = r_pc;

`ifdef WRITE_BACK_FEEDBACK_EN
  assign fb_valid = r_rf_we;
  assign fb_index = r_rf_index;
  assign fb_value = r_rf_value;
`else
  assign fb_valid = 1'b0;
  assign fb_index = '0;
  assign fb_value = '0;
`endif

endmodule

// File: tb/tb_write_back.sv
// tb/tb_write_back.sv - self-checking bench for write_back with a deferred-action reference model
module tb_write_back;
  import write_back_pkg::*;

  logic    clock = 1'b0;
  logic    reset = 1'b1;
  logic    in_valid, in_hold;
  regval_t in_pc;
  regind_t in_destination_register;
  logic    in_is_writing_memory;
  flags_t  in_flags;
  regval_t in_destination_value;
  logic    in_has_upper_value;
  regval_t in_upper_value;
  regval_t in_adjustment_value;
  logic    in_has_flushed;
  logic    rf_we;
  regind_t rf_index;
  regval_t rf_value;
  flags_t  flags_we, flags_value;
  regind_t rf_read_index;
  regval_t rf_read_value;
  logic    mem_write;
  regval_t mem_address, mem_data;
  logic    mem_wait_request;
  logic    retire_valid;
  regval_t retire_pc;
  logic    fb_valid;
  regind_t fb_index;
  regval_t fb_value;

  regval_t rfv [32];
  assign rf_read_value = rfv[rf_read_index];

  write_back dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_hold(in_hold), .in_pc(in_pc),
    .in_destination_register(in_destination_register),
    .in_is_writing_memory(in_is_writing_memory), .in_flags(in_flags),
    .in_destination_value(in_destination_value),
    .in_has_upper_value(in_has_upper_value), .in_upper_value(in_upper_value),
    .in_adjustment_value(in_adjustment_value), .in_has_flushed(in_has_flushed),
    .rf_we(rf_we), .rf_index(rf_index), .rf_value(rf_value),
    .flags_we(flags_we), .flags_value(flags_value),
    .rf_read_index(rf_read_index), .rf_read_value(rf_read_value),
    .mem_write(mem_write), .mem_address(mem_address), .mem_data(mem_data),
    .mem_wait_request(mem_wait_request),
    .retire_valid(retire_valid), .retire_pc(retire_pc),
    .fb_valid(fb_valid), .fb_index(fb_index), .fb_value(fb_value)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic armed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected outputs for the current cycle, plus deferred work the stage still owes
  typedef struct {
    regind_t idx;
    regval_t val;
    regval_t pc;
  } pend_t;
  pend_t   pend [$];
  logic    st_on = 1'b0;
  regval_t st_pc;
  logic    e_rf_we = 1'b0;
  regind_t e_idx;
  regval_t e_val;
  flags_t  e_fl_we = '0;
  flags_t  e_flv;
  logic    e_mem = 1'b0;
  regval_t e_addr, e_data;
  logic    e_ret = 1'b0;
  regval_t e_pc;
  logic    e_busy = 1'b0;

  task automatic model_step();
    pend_t p;
    e_rf_we = 1'b0;
    e_fl_we = '0;
    e_ret   = 1'b0;
    if (reset) begin
      pend.delete();
      st_on = 1'b0;
      e_mem = 1'b0;
    end else if (st_on) begin
      if (!mem_wait_request) begin
        st_on = 1'b0;
        e_mem = 1'b0;
        e_ret = 1'b1;
        e_pc  = st_pc;
      end
    end else if (pend.size() != 0) begin
      p       = pend.pop_front();
      e_rf_we = (p.idx != 0);
      e_idx   = p.idx;
      e_val   = p.val;
      e_ret   = 1'b1;
      e_pc    = p.pc;
    end else if (in_valid && !in_has_flushed) begin
      if (in_is_writing_memory) begin
        st_on  = 1'b1;
        st_pc  = in_pc;
        e_mem  = 1'b1;
        e_addr = in_destination_value + in_adjustment_value;
        e_data = rfv[in_destination_register];
      end else begin
        e_rf_we = (in_destination_register != 0);
        e_idx   = in_destination_register;
        e_val   = in_destination_value;
        e_fl_we = (in_destination_register == FLAGS_INDEX) ? 4'h0 : 4'hF;
        e_flv   = in_flags;
        if (in_has_upper_value) begin
          p.idx = regind_t'((32'(in_destination_register) + 1) % 32);
          p.val = in_upper_value;
          p.pc  = in_pc;
          pend.push_back(p);
        end else begin
          e_ret = 1'b1;
          e_pc  = in_pc;
        end
      end
    end
    e_busy = st_on || (pend.size() != 0);
  endtask

  always @(negedge clock) begin
    if (armed) begin
      chk("rf_we", 32'(rf_we), 32'(e_rf_we));
      if (e_rf_we) begin
        chk("rf_index", 32'(rf_index), 32'(e_idx));
        chk("rf_value", rf_value, e_val);
      end
      chk("flags_we", 32'(flags_we), 32'(e_fl_we));
      if (e_fl_we != 0) chk("flags_value", 32'(flags_value), 32'(e_flv));
      chk("mem_write", 32'(mem_write), 32'(e_mem));
      if (e_mem) begin
        chk("mem_address", mem_address, e_addr);
        chk("mem_data", mem_data, e_data);
      end
      chk("retire_valid", 32'(retire_valid), 32'(e_ret));
      if (e_ret) chk("retire_pc", retire_pc, e_pc);
      chk("in_hold", 32'(in_hold), 32'(reset || e_busy));
      chk("rf_read_index", 32'(rf_read_index), 32'(in_destination_register));
`ifdef WRITE_BACK_FEEDBACK_EN
      chk("fb_valid", 32'(fb_valid), 32'(e_rf_we));
      if (e_rf_we) begin
        chk("fb_index", 32'(fb_index), 32'(e_idx));
        chk("fb_value", fb_value, e_val);
      end
`else
      chk("fb_valid", 32'(fb_valid), 32'd0);
      chk("fb_index", 32'(fb_index), 32'd0);
      chk("fb_value", fb_value, 32'd0);
`endif
    end
  end

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid             = 1'b0;
    in_is_writing_memory = 1'b0;
    in_has_upper_value   = 1'b0;
    in_has_flushed       = 1'b0;
  endtask

  task automatic beat(input regind_t d, input regval_t v, input flags_t f, input logic m,
                      input logic u, input regval_t uv, input regval_t adj, input logic fl);
    in_valid                = 1'b1;
    in_pc                   = $urandom;
    in_destination_register = d;
    in_destination_value    = v;
    in_flags                = f;
    in_is_writing_memory    = m;
    in_has_upper_value      = u;
    in_upper_value          = uv;
    in_adjustment_value     = adj;
    in_has_flushed          = fl;
  endtask

  initial begin
    int r;
    for (int i = 0; i < 32; i++) rfv[i] = $urandom;
    rfv[3] = 32'hDEAD;
    idle();
    in_pc = '0; in_destination_register = '0; in_flags = '0;
    in_destination_value = '0; in_upper_value = '0; in_adjustment_value = '0;
    mem_wait_request = 1'b0;
    reset = 1'b1;
    tick();
    armed = 1'b1;
    tick();
    tick();
    chk("reset_rf_we", 32'(rf_we), 32'd0);
    chk("reset_flags_we", 32'(flags_we), 32'd0);
    chk("reset_mem_write", 32'(mem_write), 32'd0);
    chk("reset_retire", 32'(retire_valid), 32'd0);
    chk("reset_hold", 32'(in_hold), 32'd1);
    reset = 1'b0;
    tick();
    chk("idle_hold", 32'(in_hold), 32'd0);

    // add result
    beat(5'd5, 32'h1234, 4'b0001, 1'b0, 1'b0, '0, '0, 1'b0);
    tick();
    idle();
    chk("add_rf_we", 32'(rf_we), 32'd1);
    chk("add_idx", 32'(rf_index), 32'd5);
    chk("add_val", rf_value, 32'h1234);
    chk("add_flags_we", 32'(flags_we), 32'hF);
    chk("add_flags_val", 32'(flags_value), 32'h1);
    chk("add_retire", 32'(retire_valid), 32'd1);

    // multiply with upper half, wrapping r31 -> r0
    beat(5'd31, 32'hAAAA, 4'h0, 1'b0, 1'b1, 32'h5555, '0, 1'b0);
    tick();
    idle();
    chk("mul_lo_we", 32'(rf_we), 32'd1);
    chk("mul_lo_idx", 32'(rf_index), 32'd31);
    chk("mul_lo_val", rf_value, 32'hAAAA);
    chk("mul_lo_retire", 32'(retire_valid), 32'd0);
    chk("mul_hold", 32'(in_hold), 32'd1);
    tick();
    chk("mul_hi_we", 32'(rf_we), 32'd0);
    chk("mul_hi_retire", 32'(retire_valid), 32'd1);
    chk("mul_hi_hold", 32'(in_hold), 32'd0);

    // store with three wait cycles
    mem_wait_request = 1'b1;
    beat(5'd3, 32'h100, 4'h0, 1'b1, 1'b0, '0, 32'h10, 1'b0);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      chk("st_mem_write", 32'(mem_write), 32'd1);
      chk("st_addr", mem_address, 32'h110);
      chk("st_data", mem_data, 32'hDEAD);
      chk("st_rf_we", 32'(rf_we), 32'd0);
      chk("st_retire", 32'(retire_valid), 32'd0);
      if (i == 3) mem_wait_request = 1'b0;
      tick();
    end
    chk("st_done_mem_write", 32'(mem_write), 32'd0);
    chk("st_done_retire", 32'(retire_valid), 32'd1);

    // flushed beat
    beat(5'd7, 32'h77, 4'hF, 1'b0, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      idle();
      chk("fl_rf_we", 32'(rf_we), 32'd0);
      chk("fl_flags_we", 32'(flags_we), 32'd0);
      chk("fl_mem_write", 32'(mem_write), 32'd0);
      chk("fl_retire", 32'(retire_valid), 32'd0);
    end

    // reset on the second wait cycle of a store
    mem_wait_request = 1'b1;
    beat(5'd3, 32'h200, 4'h0, 1'b1, 1'b0, '0, 32'h4, 1'b0);
    tick();
    idle();
    tick();
    chk("rs_mem_write_pre", 32'(mem_write), 32'd1);
    reset = 1'b1;
    tick();
    chk("rs_mem_write", 32'(mem_write), 32'd0);
    chk("rs_retire", 32'(retire_valid), 32'd0);
    reset = 1'b0;
    mem_wait_request = 1'b0;
    tick();
    chk("rs_idle_hold", 32'(in_hold), 32'd0);
    chk("rs_retire_after", 32'(retire_valid), 32'd0);

    // direct write to the flags register
    beat(FLAGS_INDEX, 32'hF, 4'hA, 1'b0, 1'b0, '0, '0, 1'b0);
    tick();
    idle();
    chk("fx_rf_we", 32'(rf_we), 32'd1);
    chk("fx_idx", 32'(rf_index), 32'(FLAGS_INDEX));
    chk("fx_flags_we", 32'(flags_we), 32'd0);
`ifdef WRITE_BACK_FEEDBACK_EN
    chk("fx_fb_valid", 32'(fb_valid), 32'd1);
    chk("fx_fb_idx", 32'(fb_index), 32'(FLAGS_INDEX));
`else
    chk("fx_fb_valid", 32'(fb_valid), 32'd0);
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_pc = $urandom;
      r = int'($urandom_range(0, 7));
      if (r == 0) in_destination_register = 5'd0;
      else if (r == 1) in_destination_register = 5'd31;
      else if (r == 2) in_destination_register = FLAGS_INDEX;
      else in_destination_register = regind_t'($urandom_range(0, 31));
      in_destination_value = $urandom;
      in_upper_value       = $urandom;
      in_adjustment_value  = $urandom;
      in_flags             = flags_t'($urandom_range(0, 15));
      in_is_writing_memory = ($urandom_range(0, 4) == 0);
      in_has_upper_value   = ($urandom_range(0, 4) == 0);
      in_has_flushed       = ($urandom_range(0, 9) == 0);
      mem_wait_request     = ($urandom_range(0, 1) == 1);
      reset                = ($urandom_range(0, 49) == 0);
      rfv[$urandom_range(0, 31)] = $urandom;
      tick();
    end
    reset = 1'b0;
    mem_wait_request = 1'b0;
    idle();
    for (int i = 0; i < 4; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
